// File: rtl/irq_priority_encoder_pkg.sv
// Shared definitions for the interrupt priority encoder slice.
// Contents:
//   irq_state_t        - grant FSM states (IDLE / GRANT / SERVICE)
//   IRQ_N_DEFAULT      - default number of request lines
//   IRQ_IDX_W_DEFAULT  - default index width, log2 of the line count
package irq_priority_encoder_pkg;

  localparam int unsigned IRQ_N_DEFAULT     = 8;
  localparam int unsigned IRQ_IDX_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder_prio.sv
// priority_encoder: combinational N -> IDX_W encoder. The lowest set index wins.
// This block is reusable anywhere in the datapath.
// Ports:
//   vec  [N]     - input vector
//   idx  [IDX_W] - index of the lowest set bit (0 when vec is empty)
//   any          - high when any bit of vec is set
module priority_encoder #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !any) begin
        idx = i[IDX_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: registered interrupt priority encoder that uses a
// request/ack/done handshake toward the CPU control unit.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   en              - global enable. It gates new grants only.
//   req     [N]     - level request lines. Bit 0 has the highest priority.
//   mask_we, mask_d - mask register write (1 = masked)
//   ack             - control unit accepts the presented grant
//   done            - control unit has finished servicing
//   valid           - idx holds an unacknowledged grant
//   idx     [IDX_W] - granted request index. It holds its value when idle.
//   busy            - grant acknowledged and service in progress
//   pending [N]     - pending event register
module irq_priority_encoder
  import irq_priority_encoder_pkg::*;
#(
  parameter int unsigned N     = IRQ_N_DEFAULT,
  parameter int unsigned IDX_W = IRQ_IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             mask_we,
  input  logic [N-1:0]     mask_d,
  input  logic             ack,
  input  logic             done,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic             busy,
  output logic [N-1:0]     pending
);

  irq_state_t       state_q, state_d;
  logic [N-1:0]     req_q;
  logic [N-1:0]     mask_q;
  logic [N-1:0]     eligible;
  logic [N-1:0]     set_vec;
  logic [N-1:0]     clr_vec;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [IDX_W-1:0] idx_d;

  assign set_vec  = req & ~req_q;
  assign eligible = pending & ~mask_q;

  priority_encoder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_prio (
    .vec (eligible),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    clr_vec = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && enc_any) begin
          idx_d   = enc_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // ack takes priority: a simultaneous done is dropped here.
        if (ack) begin
          clr_vec[idx] = 1'b1;
          state_d      = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx     <= '0;
      req_q   <= '0;
      mask_q  <= '0;
      pending <= '0;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      req_q   <= req;
      if (mask_we) mask_q <= mask_d;
      // A new edge on the bit being acknowledged survives the clear.
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  assign valid = (state_q == ST_GRANT);
  assign busy  = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Testbench for irq_priority_encoder. It runs directed scenarios with literal
// expectations, then randomized traffic. A cycle-level behavioural model is
// compared against the DUT after every clock.
module tb_irq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] req = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_d = '0;
  logic       ack = 1'b0;
  logic       done = 1'b0;
  logic       valid;
  logic [2:0] idx;
  logic       busy;
  logic [7:0] pending;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          chk_en  = 1'b0;

  irq_priority_encoder #(.N(8), .IDX_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .mask_we (mask_we),
    .mask_d  (mask_d),
    .ack     (ack),
    .done    (done),
    .valid   (valid),
    .idx     (idx),
    .busy    (busy),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model. mode: 0 = waiting, 1 = presented, 2 = in service.
  bit [7:0] m_req_q = '0, m_pending = '0, m_mask = '0;
  int       m_mode = 0;
  int       m_idx = 0;

  always @(posedge clk) begin
    bit [7:0] elig;
    bit [7:0] nxt;
    if (rst) begin
      m_req_q = '0; m_pending = '0; m_mask = '0; m_mode = 0; m_idx = 0;
    end else begin
      elig = m_pending & ~m_mask;
      nxt  = m_pending;
      if (m_mode == 0) begin
        if (en && elig != 0) begin
          for (int i = 7; i >= 0; i--) if (elig[i]) m_idx = i;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (ack) begin
          nxt[m_idx] = 1'b0;
          m_mode = 2;
        end
      end else if (done) begin
        m_mode = 0;
      end
      m_pending = nxt | (req & ~m_req_q);
      if (mask_we) m_mask = mask_d;
      m_req_q = req;
    end
  end

  // Compare process: runs every cycle once a reset has been applied.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        chk("model_valid",   {31'd0, valid}, {31'd0, m_mode == 1});
        chk("model_busy",    {31'd0, busy},  {31'd0, m_mode == 2});
        chk("model_idx",     {29'd0, idx},   m_idx);
        chk("model_pending", {24'd0, pending}, {24'd0, m_pending});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input bit v, input bit b,
                            input logic [2:0] i, input logic [7:0] p);
    chk({tag, "_valid"},   {31'd0, valid},   {31'd0, v});
    chk({tag, "_busy"},    {31'd0, busy},    {31'd0, b});
    chk({tag, "_idx"},     {29'd0, idx},     {29'd0, i});
    chk({tag, "_pending"}, {24'd0, pending}, {24'd0, p});
  endtask

  task automatic serve;
    ack = 1'b1; cyc(1); ack = 1'b0;
    done = 1'b1; cyc(1); done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    rst = 1'b0;
    cyc(1);
    expect_out("reset", 0, 0, 3'd0, 8'h00);

    // Single request on line 5.
    req = 8'h20; cyc(1);
    expect_out("r5_pend", 0, 0, 3'd0, 8'h20);
    cyc(1);
    expect_out("r5_grant", 1, 0, 3'd5, 8'h20);
    ack = 1'b1; cyc(1); ack = 1'b0;
    expect_out("r5_ack", 0, 1, 3'd5, 8'h00);
    done = 1'b1; cyc(1); done = 1'b0;
    expect_out("r5_done", 0, 0, 3'd5, 8'h00);
    req = 8'h00; cyc(2);

    // Simultaneous edges on lines 6, 3 and 2.
    req = 8'h4C; cyc(2);
    expect_out("multi_g2", 1, 0, 3'd2, 8'h4C);
    serve();
    expect_out("multi_gap", 0, 0, 3'd2, 8'h48);
    cyc(1);
    expect_out("multi_g3", 1, 0, 3'd3, 8'h48);
    serve();
    cyc(1);
    expect_out("multi_g6", 1, 0, 3'd6, 8'h40);
    serve();
    req = 8'h00; cyc(2);

    // Mask line 2. Line 7 goes first, and line 2 waits for the unmask.
    mask_we = 1'b1; mask_d = 8'h04; cyc(1); mask_we = 1'b0;
    req = 8'h84; cyc(2);
    expect_out("mask_g7", 1, 0, 3'd7, 8'h84);
    serve();
    cyc(2);
    expect_out("mask_hold", 0, 0, 3'd7, 8'h04);
    mask_we = 1'b1; mask_d = 8'h00; cyc(1); mask_we = 1'b0;
    cyc(1);
    expect_out("unmask_g2", 1, 0, 3'd2, 8'h04);
    serve();
    req = 8'h00; cyc(2);

    // A re-edge on the acked bit survives. A line 0 edge in GRANT keeps idx.
    req = 8'h02; cyc(2);
    expect_out("re_g1", 1, 0, 3'd1, 8'h02);
    req = 8'h00; cyc(1);
    req = 8'h01; cyc(1);
    expect_out("re_l0", 1, 0, 3'd1, 8'h03);
    req = 8'h02; ack = 1'b1; cyc(1); ack = 1'b0;
    expect_out("re_ack", 0, 1, 3'd1, 8'h03);
    done = 1'b1; cyc(1); done = 1'b0;
    cyc(1);
    expect_out("re_g0", 1, 0, 3'd0, 8'h03);
    serve();
    cyc(1);
    expect_out("re_g1b", 1, 0, 3'd1, 8'h02);
    serve();
    req = 8'h00; cyc(2);

    // Enable gating, and stray ack/done while idle.
    en = 1'b0; req = 8'h10; cyc(3);
    expect_out("en_off", 0, 0, 3'd1, 8'h10);
    ack = 1'b1; done = 1'b1; cyc(1); ack = 1'b0; done = 1'b0;
    expect_out("stray", 0, 0, 3'd1, 8'h10);
    en = 1'b1; cyc(1);
    expect_out("en_on", 1, 0, 3'd4, 8'h10);
    en = 1'b0; cyc(1);
    expect_out("en_grant", 1, 0, 3'd4, 8'h10);
    en = 1'b1;
    ack = 1'b1; done = 1'b1; cyc(1); ack = 1'b0; done = 1'b0;
    expect_out("ackdone", 0, 1, 3'd4, 8'h00);
    done = 1'b1; cyc(1); done = 1'b0;
    req = 8'h00; cyc(2);

    // Reset during SERVICE with events pending.
    req = 8'h81; cyc(2);
    ack = 1'b1; cyc(1); ack = 1'b0;
    req = 8'h80; cyc(1);
    req = 8'h81; cyc(1);
    expect_out("svc_pend", 0, 1, 3'd0, 8'h81);
    rst = 1'b1; cyc(1);
    expect_out("rst_mid", 0, 0, 3'd0, 8'h00);
    rst = 1'b0; cyc(1);
    chk("rst_rel_pending", {24'd0, pending}, 32'h81);
    req = 8'h00; cyc(2);

    // Randomized traffic. The compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      en      = ($urandom_range(0, 7) != 0);
      ack     = ($urandom_range(0, 2) == 0);
      done    = ($urandom_range(0, 2) == 0);
      mask_we = ($urandom_range(0, 29) == 0);
      mask_d  = 8'($urandom) & 8'($urandom);
      rst     = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; ack = 1'b0; done = 1'b0; mask_we = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
